// File: rtl/dmem_bank_if.sv
// Request/response bundle between a load/store unit and dmem_bank.
// Scalar clock and reset stay outside the bundle.
interface dmem_bank_if #(
    parameter int ADDR_BITS = 22
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [ADDR_BITS-1:0] req_addr;
    logic [1:0]           req_size;
    logic                 req_signed;
    logic [31:0]          req_wdata;
    logic                 rsp_valid;
    logic [31:0]          rsp_rdata;
    logic                 rsp_error;
    logic                 busy;

    modport master (
        output req_valid, req_write, req_addr, req_size, req_signed, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_size, req_signed, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error, busy
    );
endinterface

// File: rtl/dmem_bank.sv
// Byte-addressable data memory with sized, extended loads, one-cycle registered
// responses, access checking and a one-word-per-cycle clear sequence after reset.
module dmem_bank #(
    parameter int DEPTH     = 1024,
    parameter int ADDR_BITS = 22
) (
    input  logic        clk,
    input  logic        reset,
    dmem_bank_if.slave  bus
);
    localparam int IDX_BITS  = $clog2(DEPTH);
    localparam int WIDX_BITS = ADDR_BITS - 2;
    localparam logic [IDX_BITS-1:0]  LAST_IDX = IDX_BITS'(DEPTH - 1);
    localparam logic [WIDX_BITS-1:0] MAX_WIDX = WIDX_BITS'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t              state;
    logic [IDX_BITS-1:0] clear_idx;
    logic                busy_reg;
    logic                ready_reg;
    logic                rsp_valid_reg;
    logic                rsp_error_reg;
    logic                load_ok_reg;
    logic [1:0]          rsp_size_reg;
    logic [1:0]          rsp_lane_reg;
    logic                rsp_signed_reg;

    logic                 accept;
    logic [WIDX_BITS-1:0] widx;
    logic [1:0]           lane;
    logic                 acc_err;
    logic [3:0]           byte_en;
    logic [31:0]          store_data;
    logic [3:0]           mem_we;
    logic [IDX_BITS-1:0]  mem_waddr;
    logic [31:0]          mem_wdata;
    logic [IDX_BITS-1:0]  rd_addr;
    logic [31:0]          rd_word;
    logic [7:0]           sel_byte;
    logic [15:0]          sel_half;
    logic [31:0]          load_data;

    assign accept = bus.req_valid & ready_reg;
    assign widx   = bus.req_addr[ADDR_BITS-1:2];
    assign lane   = bus.req_addr[1:0];

    always_comb begin
        acc_err    = 1'b0;
        byte_en    = 4'b0000;
        store_data = bus.req_wdata;
        case (bus.req_size)
            2'd0: begin
                byte_en    = 4'b0001 << lane;
                store_data = {4{bus.req_wdata[7:0]}};
            end
            2'd1: begin
                acc_err    = lane[0];
                byte_en    = lane[1] ? 4'b1100 : 4'b0011;
                store_data = {2{bus.req_wdata[15:0]}};
            end
            2'd2: begin
                acc_err = (lane != 2'd0);
                byte_en = 4'b1111;
            end
            default: acc_err = 1'b1;
        endcase
        if (widx > MAX_WIDX) begin
            acc_err = 1'b1;
        end
    end

    // The clear sequencer owns the write port until it reaches IDLE.
    always_comb begin
        if (state == ST_CLEAR) begin
            mem_we    = 4'b1111;
            mem_waddr = clear_idx;
            mem_wdata = 32'd0;
        end else begin
            mem_we    = (accept & bus.req_write & ~acc_err) ? byte_en : 4'b0000;
            mem_waddr = widx[IDX_BITS-1:0];
            mem_wdata = store_data;
        end
    end

    assign rd_addr = widx[IDX_BITS-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] rd_q;

            always_ff @(posedge clk) begin
                if (mem_we[gi]) begin
                    lane_mem[mem_waddr] <= mem_wdata[8*gi +: 8];
                end
                if (accept) begin
                    rd_q <= lane_mem[rd_addr];
                end
            end

            assign rd_word[8*gi +: 8] = rd_q;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_CLEAR;
            clear_idx      <= '0;
            busy_reg       <= 1'b1;
            ready_reg      <= 1'b0;
            rsp_valid_reg  <= 1'b0;
            rsp_error_reg  <= 1'b0;
            load_ok_reg    <= 1'b0;
            rsp_size_reg   <= 2'd0;
            rsp_lane_reg   <= 2'd0;
            rsp_signed_reg <= 1'b0;
        end else begin
            rsp_valid_reg <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    clear_idx <= clear_idx + 1'b1;
                    if (clear_idx == LAST_IDX) begin
                        state     <= ST_IDLE;
                        busy_reg  <= 1'b0;
                        ready_reg <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (accept) begin
                        rsp_valid_reg  <= 1'b1;
                        rsp_error_reg  <= acc_err;
                        load_ok_reg    <= ~bus.req_write & ~acc_err;
                        rsp_size_reg   <= bus.req_size;
                        rsp_lane_reg   <= lane;
                        rsp_signed_reg <= bus.req_signed;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

    // Extraction runs off the held request fields, so the last result persists.
    always_comb begin
        case (rsp_lane_reg)
            2'd0:    sel_byte = rd_word[7:0];
            2'd1:    sel_byte = rd_word[15:8];
            2'd2:    sel_byte = rd_word[23:16];
            default: sel_byte = rd_word[31:24];
        endcase
        sel_half = rsp_lane_reg[1] ? rd_word[31:16] : rd_word[15:0];
        case (rsp_size_reg)
            2'd0:    load_data = {{24{rsp_signed_reg & sel_byte[7]}}, sel_byte};
            2'd1:    load_data = {{16{rsp_signed_reg & sel_half[15]}}, sel_half};
            default: load_data = rd_word;
        endcase
    end

    assign bus.req_ready = ready_reg;
    assign bus.busy      = busy_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_error = rsp_error_reg;
    assign bus.rsp_rdata = load_ok_reg ? load_data : 32'd0;
endmodule

// File: tb/tb_dmem_bank.sv
// Directed bench for dmem_bank: table of sized accesses plus reset/clear sequences.
module tb_dmem_bank;
    localparam int DEPTH     = 1024;
    localparam int ADDR_BITS = 22;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    dmem_bank_if #(.ADDR_BITS(ADDR_BITS)) bus ();

    dmem_bank #(.DEPTH(DEPTH), .ADDR_BITS(ADDR_BITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic        wr;
        logic [21:0] addr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string name, logic wr, logic [21:0] addr, logic [1:0] size,
                                logic sgn, logic [31:0] wdata, logic [31:0] exp_rdata,
                                logic exp_err);
        vec_t v;
        v.name = name; v.wr = wr; v.addr = addr; v.size = size; v.sgn = sgn;
        v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic wr, logic [21:0] addr, logic [1:0] size, logic sgn, logic [31:0] wdata);
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_addr   = addr;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_wdata  = wdata;
    endtask

    task automatic idle_bus();
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_size   = 2'd0;
        bus.req_signed = 1'b0;
        bus.req_wdata  = 32'd0;
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, " busy"},      {31'd0, bus.busy},      32'd1);
        check({tag, " req_ready"}, {31'd0, bus.req_ready}, 32'd0);
        check({tag, " rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
        check({tag, " rsp_rdata"}, bus.rsp_rdata,          32'd0);
        check({tag, " rsp_error"}, {31'd0, bus.rsp_error}, 32'd0);
    endtask

    // Called at the negedge where reset is released; returns at the first negedge with busy low.
    task automatic wait_clear(string tag);
        int n = 0;
        int bad_ready = 0;
        int bad_valid = 0;
        while (bus.busy === 1'b1 && n < 2000) begin
            if (bus.req_ready !== 1'b0) bad_ready++;
            if (bus.rsp_valid !== 1'b0) bad_valid++;
            @(negedge clk);
            n++;
        end
        check({tag, " busy cycles"},       n,         DEPTH);
        check({tag, " ready during clear"}, bad_ready, 0);
        check({tag, " rsp_valid during clear"}, bad_valid, 0);
        check({tag, " ready after clear"}, {31'd0, bus.req_ready}, 32'd1);
        $display("clear %s: busy for %0d cycles", tag, n);
    endtask

    task automatic single(string name, logic wr, logic [21:0] addr, logic [1:0] size, logic sgn,
                          logic [31:0] wdata, logic [31:0] exp_rdata, logic exp_err);
        drive(wr, addr, size, sgn, wdata);
        @(negedge clk);
        idle_bus();
        check({name, " rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
        check({name, " rsp_rdata"}, bus.rsp_rdata, exp_rdata);
        check({name, " rsp_error"}, {31'd0, bus.rsp_error}, {31'd0, exp_err});
        $display("txn %s: rdata=%h err=%b", name, bus.rsp_rdata, bus.rsp_error);
    endtask

    initial begin
        idle_bus();
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b1;
        wait_clear("por");

        //   name            wr    addr       sz  sgn  wdata          exp_rdata      err
        add("ld_top0",      1'b0, 22'h0FFC, 2, 0, 32'h0,        32'h00000000, 0);
        add("st_w10",       1'b1, 22'h0010, 2, 0, 32'hDEADBEEF, 32'h00000000, 0);
        add("ld_w10",       1'b0, 22'h0010, 2, 0, 32'h0,        32'hDEADBEEF, 0);
        add("st_b21",       1'b1, 22'h0021, 0, 0, 32'hFFFFFF80, 32'h00000000, 0);
        add("ld_b21_s",     1'b0, 22'h0021, 0, 1, 32'h0,        32'hFFFFFF80, 0);
        add("ld_b21_u",     1'b0, 22'h0021, 0, 0, 32'h0,        32'h00000080, 0);
        add("ld_w20",       1'b0, 22'h0020, 2, 1, 32'h0,        32'h00008000, 0);
        add("st_h32",       1'b1, 22'h0032, 1, 0, 32'h1234A5A5, 32'h00000000, 0);
        add("ld_h32_s",     1'b0, 22'h0032, 1, 1, 32'h0,        32'hFFFFA5A5, 0);
        add("ld_w30",       1'b0, 22'h0030, 2, 0, 32'h0,        32'hA5A50000, 0);
        add("ld_h30_s",     1'b0, 22'h0030, 1, 1, 32'h0,        32'h00000000, 0);
        add("ld_h32_u",     1'b0, 22'h0032, 1, 0, 32'h0,        32'h0000A5A5, 0);
        add("ld_b32_s",     1'b0, 22'h0032, 0, 1, 32'h0,        32'hFFFFFFA5, 0);
        add("ld_b33_u",     1'b0, 22'h0033, 0, 0, 32'h0,        32'h000000A5, 0);
        add("st_w42_mis",   1'b1, 22'h0042, 2, 0, 32'h12345678, 32'h00000000, 1);
        add("st_h43_mis",   1'b1, 22'h0043, 1, 0, 32'h00005678, 32'h00000000, 1);
        add("st_sz3",       1'b1, 22'h0040, 3, 0, 32'hFFFFFFFF, 32'h00000000, 1);
        add("st_w1000_oor", 1'b1, 22'h1000, 2, 0, 32'hFFFFFFFF, 32'h00000000, 1);
        add("ld_w40",       1'b0, 22'h0040, 2, 0, 32'h0,        32'h00000000, 0);
        add("ld_w00",       1'b0, 22'h0000, 2, 0, 32'h0,        32'h00000000, 0);
        add("st_b13",       1'b1, 22'h0013, 0, 0, 32'h00000011, 32'h00000000, 0);
        add("ld_w10_b",     1'b0, 22'h0010, 2, 0, 32'h0,        32'h11ADBEEF, 0);
        add("ld_h12_s",     1'b0, 22'h0012, 1, 1, 32'h0,        32'h000011AD, 0);
        add("ld_h10_s",     1'b0, 22'h0010, 1, 1, 32'h0,        32'hFFFFBEEF, 0);
        add("ld_w11_mis",   1'b0, 22'h0011, 2, 0, 32'h0,        32'h00000000, 1);
        add("ld_h3ffe_oor", 1'b0, 22'h3FFE, 1, 1, 32'h0,        32'h00000000, 1);
        add("st_wffc",      1'b1, 22'h0FFC, 2, 0, 32'hCAFEF00D, 32'h00000000, 0);
        add("ld_bffd_u",    1'b0, 22'h0FFD, 0, 0, 32'h0,        32'h000000F0, 0);
        add("ld_bfff_s",    1'b0, 22'h0FFF, 0, 1, 32'h0,        32'hFFFFFFCA, 0);

        // Back-to-back: each negedge checks the previous response and drives the next request.
        for (int i = 0; i < vecs.size(); i++) begin
            check({vecs[i].name, " req_ready"}, {31'd0, bus.req_ready}, 32'd1);
            drive(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].sgn, vecs[i].wdata);
            @(negedge clk);
            check({vecs[i].name, " rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
            check({vecs[i].name, " rsp_rdata"}, bus.rsp_rdata, vecs[i].exp_rdata);
            check({vecs[i].name, " rsp_error"}, {31'd0, bus.rsp_error}, {31'd0, vecs[i].exp_err});
            $display("txn %0d %s: rdata=%h err=%b", i, vecs[i].name, bus.rsp_rdata, bus.rsp_error);
        end
        idle_bus();
        @(negedge clk);
        check("tail rsp_valid low", {31'd0, bus.rsp_valid}, 32'd0);
        check("tail rdata held",    bus.rsp_rdata, 32'hFFFFFFCA);
        check("tail error held",    {31'd0, bus.rsp_error}, 32'd0);

        // Reset in the middle of the clear sequence.
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_outputs("reset idle");
        @(negedge clk);
        reset = 1'b1;
        repeat (500) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_reset_outputs("reset mid-clear");
        @(negedge clk);
        reset = 1'b1;
        wait_clear("after mid-clear");
        single("ld_w10_cleared", 1'b0, 22'h0010, 2, 0, 32'h0, 32'h00000000, 0);
        single("st_w44",         1'b1, 22'h0044, 2, 0, 32'h5555AAAA, 32'h00000000, 0);
        single("ld_w44",         1'b0, 22'h0044, 2, 0, 32'h0, 32'h5555AAAA, 0);

        // Reset right after a load is accepted: its response must be dropped.
        @(negedge clk);
        drive(1'b0, 22'h0044, 2'd2, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        idle_bus();
        check_reset_outputs("reset after accept");
        @(negedge clk);
        check("dropped rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        reset = 1'b1;
        wait_clear("after accept reset");
        single("ld_w44_cleared", 1'b0, 22'h0044, 2, 0, 32'h0, 32'h00000000, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dmem_bank.md
# dmem_bank

Parametrised, synchronous data memory for the PikaCPU load/store path, replacing the flat word-only combinational data memory. It accepts byte, halfword and word accesses at byte addresses through a valid/ready request port. It returns a registered, sign- or zero-extended response one cycle later and flags misaligned or out-of-range accesses. After reset it clears the whole array with a sequencer that runs one word per cycle, instead of zeroing it in a single step.

## Interface
Parameters:
- DEPTH, 1024: number of 32-bit words; power of two, ≥ 2.
- ADDR_BITS, 22: byte-address width; must satisfy 4·DEPTH ≤ 2^ADDR_BITS.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_BITS  byte address.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_error  out  1  accompanies rsp_valid; access was rejected.
- busy  out  1  clear sequence in progress.

## Operation
- The block has two states: CLEAR and IDLE.
- While reset is low: state = CLEAR, clear_idx = 0, busy = 1, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_error = 0.
- CLEAR:
  - Each cycle writes 0 to word clear_idx, then increments clear_idx.
  - After writing word DEPTH−1, the block moves to IDLE.
  - req_ready = 0 throughout. A requester holds its request until req_ready rises.
- IDLE: req_ready = 1, busy = 0. A request is accepted on any edge where req_valid & req_ready.
- Decode at accept:
  - widx = req_addr[ADDR_BITS−1:2]
  - lane = req_addr[1:0]
- Error when any of the following holds:
  - req_size = 3;
  - size = half and lane[0] = 1;
  - size = word and lane ≠ 0;
  - widx ≥ DEPTH.
  
  An errored access writes nothing and responds with rsp_error = 1, rsp_rdata = 0.
- Store, no error (memory updated on the accept edge):
  - Byte: writes req_wdata[7:0] into bits [8·lane+7 : 8·lane].
  - Half: writes req_wdata[15:0] into bits [16·lane[1]+15 : 16·lane[1]].
  - Word: writes all 32 bits.
  - Bytes outside the selected lanes are unchanged.
  - Response: rsp_rdata = 0, rsp_error = 0.
- Load, no error:
  - The selected byte or half is extracted, right-aligned, and extended to 32 bits.
  - Sign extension uses its MSB when req_signed = 1; otherwise it is zero-extended.
  - Word loads ignore req_signed.
- Responses have no backpressure; the consumer must always accept rsp_valid.

## Timing
- Clear duration: DEPTH cycles after reset deasserts. The first request can be accepted on edge DEPTH+1 after reset release.
- Latency 1: rsp_valid is high for exactly the cycle after the accept edge, together with rsp_rdata and rsp_error. At all other times rsp_valid = 0. rsp_rdata and rsp_error hold their last values while rsp_valid = 0.
- Throughput: one request per cycle; back-to-back accepts produce back-to-back responses.
- Read-after-write: a load accepted the cycle after a store to the same word returns the updated data. A store and a load never share an accept edge, since there is only one request port.
- Reset mid-operation:
  - Asserting reset during CLEAR or IDLE immediately forces every output to its reset value.
  - Any pending response is dropped.
  - The clear sequence restarts from word 0.
- Memory contents are undefined only while reset is low and during CLEAR. Every word reads 0 once busy falls.

## Test plan
- Reset, then hold reset high → busy = 1 and req_ready = 0 for exactly 1024 cycles. Then load word 0x0FFC → rsp_rdata = 0x00000000, rsp_error = 0.
- Store word 0xDEADBEEF to 0x0010, then load word 0x0010 on the next cycle → rsp_valid on consecutive cycles, load returns 0xDEADBEEF.
- Store byte 0x80 to 0x0021, then load byte 0x0021 signed → 0xFFFFFF80. The same load unsigned → 0x00000080. Load word 0x0020 → 0x00008000.
- Store half 0xA5A5 to 0x0032, then load half signed → 0xFFFFA5A5. Load word 0x0030 → 0xA5A50000.
- Misaligned word at 0x0042, misaligned half at 0x0043, size 3, and word at 0x1000 (widx 1024) → each gives rsp_error = 1, rsp_rdata = 0, and a later load of the touched words is unchanged.
- Assert reset during CLEAR at clear_idx = 500, and again one cycle after an accepted load → rsp_valid never pulses, and busy lasts a full 1024 cycles after each release.
